// File: rtl/dac_spi_tx.sv
// Serial transmitter for a 12-bit SPI DAC: one 16-bit frame {00, PD, data} per accepted sample,
// MSB first, with data changing on rising SCLK so the DAC can sample on falling SCLK.
module dac_spi_tx #(
   parameter int         CLK_DIV    = 3,
   parameter logic [1:0] PD_MODE    = 2'b00,
   parameter int         GAP_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ena,
   input  logic [11:0] sample_data,
   input  logic        sample_valid,
   output logic        sample_ready,
   output logic        dac_sync_n,
   output logic        dac_sclk,
   output logic        dac_din,
   output logic        frame_done
);
   localparam int HW = $clog2(CLK_DIV + 1);
   localparam int GW = $clog2(GAP_CYCLES + 1);
   localparam logic [HW-1:0] HALF_LAST = HW'(CLK_DIV - 1);
   localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_GAP   = 2'd2
   } state_t;

   state_t        state_reg, state_next;
   logic [15:0]   frame_reg, frame_next;
   logic [HW-1:0] half_cnt_reg, half_cnt_next;
   logic [4:0]    bit_cnt_reg, bit_cnt_next;
   logic [GW-1:0] gap_cnt_reg, gap_cnt_next;
   logic          ready_reg, ready_next;
   logic          sync_n_reg, sync_n_next;
   logic          sclk_reg, sclk_next;
   logic          din_reg, din_next;
   logic          done_reg, done_next;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg    <= S_IDLE;
         frame_reg    <= '0;
         half_cnt_reg <= '0;
         bit_cnt_reg  <= '0;
         gap_cnt_reg  <= '0;
         ready_reg    <= 1'b0;
         sync_n_reg   <= 1'b1;
         sclk_reg     <= 1'b1;
         din_reg      <= 1'b0;
         done_reg     <= 1'b0;
      end else begin
         state_reg    <= state_next;
         frame_reg    <= frame_next;
         half_cnt_reg <= half_cnt_next;
         bit_cnt_reg  <= bit_cnt_next;
         gap_cnt_reg  <= gap_cnt_next;
         ready_reg    <= ready_next;
         sync_n_reg   <= sync_n_next;
         sclk_reg     <= sclk_next;
         din_reg      <= din_next;
         done_reg     <= done_next;
      end
   end

   always_comb begin
      state_next    = state_reg;
      frame_next    = frame_reg;
      half_cnt_next = half_cnt_reg;
      bit_cnt_next  = bit_cnt_reg;
      gap_cnt_next  = gap_cnt_reg;
      ready_next    = ready_reg;
      sync_n_next   = sync_n_reg;
      sclk_next     = sclk_reg;
      din_next      = din_reg;
      done_next     = 1'b0;
      case (state_reg)
         S_IDLE: begin
            ready_next = ena;
            if (sample_valid && ready_reg) begin
               frame_next    = {2'b00, PD_MODE, sample_data};
               ready_next    = 1'b0;
               sync_n_next   = 1'b0;
               sclk_next     = 1'b1;
               din_next      = 1'b0;
               half_cnt_next = '0;
               bit_cnt_next  = '0;
               state_next    = S_SHIFT;
            end
         end
         S_SHIFT: begin
            if (half_cnt_reg == HALF_LAST) begin
               half_cnt_next = '0;
               if (sclk_reg) begin
                  sclk_next    = 1'b0;
                  bit_cnt_next = bit_cnt_reg + 5'd1;
               end else if (bit_cnt_reg == 5'd16) begin
                  // 16th rising toggle closes the frame
                  sync_n_next  = 1'b1;
                  sclk_next    = 1'b1;
                  din_next     = 1'b0;
                  done_next    = 1'b1;
                  gap_cnt_next = '0;
                  state_next   = S_GAP;
               end else begin
                  sclk_next  = 1'b1;
                  frame_next = {frame_reg[14:0], 1'b0};
                  din_next   = frame_reg[14];
               end
            end else begin
               half_cnt_next = half_cnt_reg + HW'(1);
            end
         end
         S_GAP: begin
            if (gap_cnt_reg == GAP_LAST) begin
               gap_cnt_next = '0;
               ready_next   = ena;
               state_next   = S_IDLE;
            end else begin
               gap_cnt_next = gap_cnt_reg + GW'(1);
            end
         end
         default: begin
            state_next  = S_IDLE;
            ready_next  = 1'b0;
            sync_n_next = 1'b1;
            sclk_next   = 1'b1;
            din_next    = 1'b0;
         end
      endcase
   end

   assign sample_ready = ready_reg;
   assign dac_sync_n   = sync_n_reg;
   assign dac_sclk     = sclk_reg;
   assign dac_din      = din_reg;
   assign frame_done   = done_reg;
endmodule
